// File: rtl/discount_add_arbiter_if.sv
// Request/response bundle between the sale-controller requesters and the shared discount adder.
// No storage; pure wiring. master = requester/consumer side, slave = arbiter side.
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready for the single result.
interface discount_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 1024,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );
endinterface

// File: rtl/discount_add_arbiter.sv
// Round-robin shared chunk-serial W-bit adder serving NREQ discount requesters.
// Latency: accept edge t, rsp_valid high in cycle t+NCHUNK+1; one op in flight.
// Backpressure: result held in DONE until rsp_ready; no grants outside IDLE.
module discount_add_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int K          = 16,
  parameter int NREQ       = 4,
  parameter int CHUNK_W    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  discount_add_arbiter_if.slave bus
);
  localparam int W      = K * DATA_WIDTH;
  localparam int NCHUNK = W / CHUNK_W;
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, work_id_q, rsp_id_q, gnt_id, idx_b;
  logic [CNTW-1:0]    chunk_q;
  logic [W-1:0]       a_q, b_q, work_sum_q, rsp_sum_q, next_sum, sel_a, sel_b;
  logic [NREQ-1:0]    grant;
  logic               gnt_any, carry_q, rsp_carry_q, chunk_co, last_chunk, accept;
  logic [CHUNK_W-1:0] chunk_sum;

  // First valid requester at or after rr_ptr (with wrap) wins the grant.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx_b   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_b = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_any && bus.req_valid[idx_b]) begin
        gnt_any      = 1'b1;
        grant[idx_b] = 1'b1;
        gnt_id       = idx_b;
      end
    end
  end

  // Operand mux driven by the one-hot grant, so no operand-dependent index math.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
      end
    end
  end

  // One CHUNK_W slice per cycle; operands shift down so the adder always sees bit 0.
  assign {chunk_co, chunk_sum} = {1'b0, a_q[CHUNK_W-1:0]} + {1'b0, b_q[CHUNK_W-1:0]}
                                 + {{CHUNK_W{1'b0}}, carry_q};
  assign last_chunk = (chunk_q == CNTW'(NCHUNK - 1));
  assign accept     = (state_q == IDLE) && gnt_any;

  // Merge the current chunk result into its slot of the running sum.
  always_comb begin
    next_sum = work_sum_q;
    for (int c = 0; c < NCHUNK; c++) begin
      if (chunk_q == CNTW'(c)) next_sum[c*CHUNK_W +: CHUNK_W] = chunk_sum;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: grant -> ADD, last chunk -> DONE, consumer handshake -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any)       state_d = ADD;
      ADD:     if (last_chunk)    state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step the carry chain in ADD, publish on last chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      work_id_q   <= '0;
      rsp_id_q    <= '0;
      chunk_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      work_sum_q  <= '0;
      rsp_sum_q   <= '0;
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else if (accept) begin
      a_q       <= sel_a;
      b_q       <= sel_b;
      work_id_q <= gnt_id;
      carry_q   <= 1'b0;
      chunk_q   <= '0;
      rr_ptr_q  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (state_q == ADD) begin
      a_q        <= a_q >> CHUNK_W;
      b_q        <= b_q >> CHUNK_W;
      work_sum_q <= next_sum;
      carry_q    <= chunk_co;
      if (last_chunk) begin
        rsp_sum_q   <= next_sum;
        rsp_carry_q <= chunk_co;
        rsp_id_q    <= work_id_q;
      end else begin
        chunk_q <= chunk_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? grant : '0;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
